bcd_counter_ctrl: RTL and testbench

Controller that owns the 4-digit BCD count shown on the seven-segment display and sequences it from the five debounced button pulses. Three modes:
- EDIT: per-digit editing with a blinking cursor.
- RUN: free-running increment at a divided tick.
- PAUSE: whole-value up/down stepping.
It sits between the button debouncers and the segment lookup/driver. It emits BCD digits plus a per-digit blank mask, so no binary-to-decimal division is needed downstream.

---
 rtl/bcd_counter_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_bcd_counter_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_ctrl.sv
// bcd_counter_ctrl -- owns the 4-digit BCD count for the seven-segment display.
//
// Three modes, sequenced by five debounced single-cycle button pulses:
//   EDIT  : per-digit editing; left/right move the cursor, up/down change the selected digit
//           mod 10 with no carry, and the selected digit blinks.
//   RUN   : the value increments (BCD, full carry) once every TICK_DIV clocks.
//   PAUSE : up/down step the whole value with carry/borrow; left/right return to EDIT.
// Only the highest-priority pulse in a cycle acts: center > left > right > up > down.
//
// Parameters
//   TICK_DIV  : clk cycles per RUN increment (>= 2)
//   BLINK_DIV : clk cycles per cursor blink half-period (>= 2)
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   btn_up       single-cycle pulse, debounced
//   btn_down     single-cycle pulse, debounced
//   btn_left     single-cycle pulse, debounced
//   btn_right    single-cycle pulse, debounced
//   btn_center   single-cycle pulse, debounced
//   digits       BCD value; [15:12] thousands .. [3:0] ones (registered)
//   blank_mask   1 = blank that digit; bit3 thousands .. bit0 ones (registered)
//   cursor       selected digit in EDIT; 0 = ones, 3 = thousands (registered)
//   running      high while in RUN (registered)
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   Defined     : in RUN and PAUSE leading zero digits are blanked (the ones digit never is).
//   Not defined : blank_mask is 0 in RUN and PAUSE.
//   EDIT behaves identically either way.

module bcd_counter_ctrl #(
  parameter int unsigned TICK_DIV  = 12000000,
  parameter int unsigned BLINK_DIV = 6000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  output logic [15:0] digits,
  output logic [3:0]  blank_mask,
  output logic [1:0]  cursor,
  output logic        running
);

  localparam int unsigned TickW  = (TICK_DIV  > 2) ? $clog2(TICK_DIV)  : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  localparam logic [TickW-1:0]  TickMax  = TickW'(TICK_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    StEdit,
    StRun,
    StPause
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // BCD helpers. Out-of-range nibbles are folded back into 0..9 so a corrupted value can never
  // propagate a non-BCD digit.
  // ---------------------------------------------------------------------------------------------
  function automatic logic [3:0] nib_inc(input logic [3:0] n);
    return (n >= 4'd9) ? 4'd0 : n + 4'd1;
  endfunction

  function automatic logic [3:0] nib_dec(input logic [3:0] n);
    if (n == 4'd0 || n > 4'd9) begin
      return 4'd9;
    end
    return n - 4'd1;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        r[i*4 +: 4] = nib_inc(v[i*4 +: 4]);
        carry       = (v[i*4 +: 4] >= 4'd9);
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        r[i*4 +: 4] = nib_dec(v[i*4 +: 4]);
        borrow      = (v[i*4 +: 4] == 4'd0);
      end
    end
    return r;
  endfunction

  // Blank mask shown while the value is counting (RUN / PAUSE).
  function automatic logic [3:0] count_blank(input logic [15:0] v);
    logic [3:0] m;
    m = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    m[3] = (v[15:12] == 4'd0);
    m[2] = m[3] && (v[11:8] == 4'd0);
    m[1] = m[2] && (v[7:4] == 4'd0);
`else
    m = 4'b0000 & {4{v[0]}};
`endif
    return m;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [15:0]         digits_q, digits_d;
  logic [1:0]          cursor_q, cursor_d;
  logic [3:0]          blank_q, blank_d;
  logic                running_q, running_d;
  logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
  logic                blink_off_q, blink_off_d;
  logic [3:0]          sel_lsb;

  // Bit offset of the selected digit inside digits_q.
  assign sel_lsb = {cursor_q, 2'b00};

  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    cursor_d    = cursor_q;
    // Both dividers idle at 0 outside the mode that uses them.
    tick_cnt_d  = '0;
    blink_cnt_d = '0;
    blink_off_d = 1'b0;

    case (state_q)
      StEdit: begin
        if (blink_cnt_q == BlinkMax) begin
          blink_cnt_d = '0;
          blink_off_d = ~blink_off_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BlinkW'(1);
          blink_off_d = blink_off_q;
        end

        // Any action restarts the blink so the edited digit is visible immediately.
        if (btn_center) begin
          state_d     = StRun;
          blink_cnt_d = '0;
          blink_off_d = 1'b0;
        end else if (btn_left) begin
          cursor_d    = cursor_q + 2'd1;
          blink_cnt_d = '0;
          blink_off_d = 1'b0;
        end else if (btn_right) begin
          cursor_d    = cursor_q - 2'd1;
          blink_cnt_d = '0;
          blink_off_d = 1'b0;
        end else if (btn_up) begin
          digits_d[sel_lsb +: 4] = nib_inc(digits_q[sel_lsb +: 4]);
          blink_cnt_d            = '0;
          blink_off_d            = 1'b0;
        end else if (btn_down) begin
          digits_d[sel_lsb +: 4] = nib_dec(digits_q[sel_lsb +: 4]);
          blink_cnt_d            = '0;
          blink_off_d            = 1'b0;
        end
      end

      StRun: begin
        // A tick coinciding with center is still applied before pausing.
        if (tick_cnt_q == TickMax) begin
          tick_cnt_d = '0;
          digits_d   = bcd_inc(digits_q);
        end else begin
          tick_cnt_d = tick_cnt_q + TickW'(1);
        end

        if (btn_center) begin
          state_d    = StPause;
          tick_cnt_d = '0;
        end
      end

      StPause: begin
        if (btn_center) begin
          state_d = StRun;
        end else if (btn_left || btn_right) begin
          state_d  = StEdit;
          cursor_d = 2'd0;
        end else if (btn_up) begin
          digits_d = bcd_inc(digits_q);
        end else if (btn_down) begin
          digits_d = bcd_dec(digits_q);
        end
      end

      default: begin
        state_d = StEdit;
      end
    endcase

    // Outputs are registered, so derive them from the next state.
    running_d = (state_d == StRun);
    if (state_d == StEdit) begin
      blank_d = blink_off_d ? (4'b0001 << cursor_d) : 4'b0000;
    end else begin
      blank_d = count_blank(digits_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEdit;
      digits_q    <= 16'h0000;
      cursor_q    <= 2'd0;
      blank_q     <= 4'b0000;
      running_q   <= 1'b0;
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      cursor_q    <= cursor_d;
      blank_q     <= blank_d;
      running_q   <= running_d;
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign digits     = digits_q;
  assign blank_mask = blank_q;
  assign cursor     = cursor_q;
  assign running    = running_q;

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Directed self-checking bench for bcd_counter_ctrl with TICK_DIV=4, BLINK_DIV=3.
// Inputs change and outputs are sampled 1 time unit after the rising edge.

module tb_bcd_counter_ctrl;

  localparam logic [4:0] BC = 5'b10000;
  localparam logic [4:0] BL = 5'b01000;
  localparam logic [4:0] BR = 5'b00100;
  localparam logic [4:0] BU = 5'b00010;
  localparam logic [4:0] BD = 5'b00001;

  logic        clk;
  logic        rst;
  logic        btn_up, btn_down, btn_left, btn_right, btn_center;
  logic [15:0] digits;
  logic [3:0]  blank_mask;
  logic [1:0]  cursor;
  logic        running;

  int n_vec;
  int n_err;

  bcd_counter_ctrl #(
    .TICK_DIV  (4),
    .BLINK_DIV (3)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_center (btn_center),
    .digits     (digits),
    .blank_mask (blank_mask),
    .cursor     (cursor),
    .running    (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected blank mask while counting (RUN/PAUSE).
  function automatic logic [15:0] exp_cnt_blank(input logic [15:0] v);
`ifdef LEADING_ZERO_BLANK_EN
    if (v[15:4] == 12'h000) return 16'hE;
    if (v[15:8] == 8'h00)   return 16'hC;
    if (v[15:12] == 4'h0)   return 16'h8;
    return 16'h0;
`else
    return (v == 16'hFFFF) ? 16'h1 : 16'h0;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle button pulse; {center, left, right, up, down}.
  task automatic press(input logic [4:0] b);
    {btn_center, btn_left, btn_right, btn_up, btn_down} = b;
    @(posedge clk);
    #1;
    {btn_center, btn_left, btn_right, btn_up, btn_down} = 5'b00000;
  endtask

  task automatic press_n(input logic [4:0] b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    {btn_center, btn_left, btn_right, btn_up, btn_down} = 5'b00000;
    step(2);
    check_eq("rst_digits", digits, 16'h0000);
    check_eq("rst_cursor", {14'd0, cursor}, 16'd0);
    check_eq("rst_running", {15'd0, running}, 16'd0);
    check_eq("rst_blank", {12'd0, blank_mask}, 16'd0);
    rst = 1'b0;

    // 1. EDIT cursor moves and digit edits.
    press_n(BL, 2);
    press_n(BU, 3);
    check_eq("edit_cursor2", {14'd0, cursor}, 16'd2);
    check_eq("edit_0300", digits, 16'h0300);
    press(BL);
    press(BD);
    check_eq("edit_cursor3", {14'd0, cursor}, 16'd3);
    check_eq("edit_9300", digits, 16'h9300);
    press(BL);
    check_eq("cursor_wrap_3_0", {14'd0, cursor}, 16'd0);
    press(BR);
    check_eq("cursor_wrap_0_3", {14'd0, cursor}, 16'd3);
    press(BU);
    check_eq("digit_wrap_nocarry", digits, 16'h0300);

    // 2. Build 9999, then RUN and watch the tick cadence.
    press(BD);                       // 9300
    press(BR);
    press_n(BD, 4);                  // 9900
    press(BR);
    press(BD);                       // 9990
    press(BR);
    press(BD);                       // 9999
    check_eq("edit_9999", digits, 16'h9999);
    press(BC);
    check_eq("run_entry_running", {15'd0, running}, 16'd1);
    check_eq("run_entry_blank", {12'd0, blank_mask}, exp_cnt_blank(16'h9999));
    step(3);
    check_eq("run_before_tick", digits, 16'h9999);
    step(1);
    check_eq("run_wrap_0000", digits, 16'h0000);
    step(3);
    check_eq("run_no_early_tick", digits, 16'h0000);
    step(1);
    check_eq("run_second_tick", digits, 16'h0001);
    check_eq("run_blank_0001", {12'd0, blank_mask}, exp_cnt_blank(16'h0001));

    // 3. PAUSE stepping with carry/borrow.
    press(BC);
    check_eq("pause_running", {15'd0, running}, 16'd0);
    check_eq("pause_hold", digits, 16'h0001);
    press(BD);
    check_eq("pause_dn_0000", digits, 16'h0000);
    check_eq("pause_blank_0000", {12'd0, blank_mask}, exp_cnt_blank(16'h0000));
    press(BD);
    check_eq("pause_borrow_9999", digits, 16'h9999);
    press(BU);
    check_eq("pause_carry_0000", digits, 16'h0000);
    press(BL);
    check_eq("pause_to_edit_cursor", {14'd0, cursor}, 16'd0);
    check_eq("pause_to_edit_running", {15'd0, running}, 16'd0);
    press(BD);                       // 0009
    press(BL);
    press(BD);                       // 0099
    press(BL);
    press(BU);                       // 0199
    check_eq("edit_0199", digits, 16'h0199);
    press(BC);                       // RUN, tick counter 0
    press(BC);                       // PAUSE, no tick yet
    check_eq("pause_0199", digits, 16'h0199);
    press(BU);
    check_eq("pause_carry_0200", digits, 16'h0200);

    // 4. Same-cycle priority.
    press(BR);                       // back to EDIT, cursor 0
    press(BC | BU);
    check_eq("cu_running", {15'd0, running}, 16'd1);
    check_eq("cu_digits", digits, 16'h0200);
    press(BU);                       // ignored in RUN, tick count 1
    step(2);                         // tick count 3
    check_eq("run_ignore_up", digits, 16'h0200);
    press(BC);                       // tick and center together
    check_eq("center_tick_digits", digits, 16'h0201);
    check_eq("center_tick_running", {15'd0, running}, 16'd0);
    step(5);
    check_eq("pause_no_tick", digits, 16'h0201);

    // 5. Blink.
    press(BL);                       // EDIT, cursor 0
    press(BL | BU);                  // left wins over up
    check_eq("lu_cursor", {14'd0, cursor}, 16'd1);
    check_eq("lu_digits", digits, 16'h0201);
    check_eq("blink_entry", {12'd0, blank_mask}, 16'h0);
    step(2);
    check_eq("blink_still_on", {12'd0, blank_mask}, 16'h0);
    step(1);
    check_eq("blink_off", {12'd0, blank_mask}, 16'h2);
    step(3);
    check_eq("blink_on_again", {12'd0, blank_mask}, 16'h0);
    step(3);
    check_eq("blink_off_again", {12'd0, blank_mask}, 16'h2);
    press(BR);
    check_eq("move_unblank", {12'd0, blank_mask}, 16'h0);
    check_eq("move_cursor0", {14'd0, cursor}, 16'd0);
    step(2);
    press(BU);                       // edit restarts the blink
    check_eq("edit_0202", digits, 16'h0202);
    step(2);
    check_eq("edit_restart_blink", {12'd0, blank_mask}, 16'h0);
    step(1);
    check_eq("edit_blink_off", {12'd0, blank_mask}, 16'h1);

    // 6. Reset mid-RUN overriding a pending tick.
    do_reset();
    check_eq("rst2_digits", digits, 16'h0000);
    press_n(BU, 7);
    press(BL);
    press_n(BU, 5);
    check_eq("edit_0057", digits, 16'h0057);
    press(BC);
    check_eq("run_blank_0057", {12'd0, blank_mask}, exp_cnt_blank(16'h0057));
    press(BC);
    check_eq("pause_0057", digits, 16'h0057);
    check_eq("pause_blank_0057", {12'd0, blank_mask}, exp_cnt_blank(16'h0057));
    press(BC);                       // RUN, tick counter 0
    step(3);                         // tick pending on next edge
    check_eq("run_pre_rst", digits, 16'h0057);
    do_reset();
    check_eq("rst3_digits", digits, 16'h0000);
    check_eq("rst3_cursor", {14'd0, cursor}, 16'd0);
    check_eq("rst3_running", {15'd0, running}, 16'd0);
    check_eq("rst3_blank", {12'd0, blank_mask}, 16'h0);
    step(4);
    check_eq("rst3_edit_no_run", digits, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
